// File: rtl/env_grid_evap_if.sv
// Write port of the environment grid: target cell, write mode, payload and the
// registered take acknowledgement returned to the ant controller.
interface env_grid_evap_if #(
  parameter int unsigned PIXELS_X    = 64,
  parameter int unsigned PIXELS_Y    = 48,
  parameter int unsigned SIGNAL_BITS = 8,
  parameter int unsigned SUGAR_BITS  = 4
);
  localparam int unsigned X_BITS = $clog2(PIXELS_X);
  localparam int unsigned Y_BITS = $clog2(PIXELS_Y);

  logic [X_BITS-1:0]      write_X;
  logic [Y_BITS-1:0]      write_Y;
  logic                   write_en;
  logic [1:0]             write_mode;
  logic [SIGNAL_BITS-1:0] write_signal;
  logic [SUGAR_BITS-1:0]  write_sugar;
  logic                   take_ok;

  modport master (
    output write_X, write_Y, write_en, write_mode, write_signal, write_sugar,
    input  take_ok
  );
  modport slave (
    input  write_X, write_Y, write_en, write_mode, write_signal, write_sugar,
    output take_ok
  );
endinterface

// File: rtl/env_grid_evap.sv
// Pheromone/sugar grid with two combinational read ports, a moded write port
// and a one-cell-per-cycle evaporation sweeper.
module env_grid_evap #(
  parameter int unsigned PIXELS_X    = 64,
  parameter int unsigned PIXELS_Y    = 48,
  parameter int unsigned SIGNAL_BITS = 8,
  parameter int unsigned SUGAR_BITS  = 4,
  parameter int unsigned DECAY_SHIFT = 3,
  localparam int unsigned X_BITS     = $clog2(PIXELS_X),
  localparam int unsigned Y_BITS     = $clog2(PIXELS_Y)
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM_n,
  env_grid_evap_if.slave         wr,
  input  logic [X_BITS-1:0]      lookup_X,
  input  logic [Y_BITS-1:0]      lookup_Y,
  output logic [SIGNAL_BITS-1:0] lookup_signal,
  output logic [SUGAR_BITS-1:0]  lookup_sugar,
  input  logic [X_BITS-1:0]      render_X,
  input  logic [Y_BITS-1:0]      render_Y,
  output logic [SIGNAL_BITS-1:0] render_signal,
  output logic [SUGAR_BITS-1:0]  render_sugar,
  input  logic                   evap_start,
  output logic                   evap_busy,
  output logic                   evap_done
);
  localparam int unsigned CELLS    = PIXELS_X * PIXELS_Y;
  localparam int unsigned IDX_BITS = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e                 state_q, state_d;
  logic [X_BITS-1:0]      ptr_x_q, ptr_x_d;
  logic [Y_BITS-1:0]      ptr_y_q, ptr_y_d;
  logic                   take_ok_q, take_ok_d;
  logic [SIGNAL_BITS-1:0] sig_q [CELLS];
  logic [SIGNAL_BITS-1:0] sig_d [CELLS];
  logic [SUGAR_BITS-1:0]  sug_q [CELLS];
  logic [SUGAR_BITS-1:0]  sug_d [CELLS];

  logic                   wr_hit, collide;
  logic [IDX_BITS-1:0]    wr_idx, sw_idx;
  logic [SIGNAL_BITS-1:0] sw_sig, decay_amt;
  logic [SIGNAL_BITS:0]   dep_sum;

  function automatic logic in_grid(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y);
    return (32'(x) < PIXELS_X) && (32'(y) < PIXELS_Y);
  endfunction

  function automatic logic [IDX_BITS-1:0] cell_idx(input logic [X_BITS-1:0] x,
                                                   input logic [Y_BITS-1:0] y);
    return IDX_BITS'(32'(y) * PIXELS_X + 32'(x));
  endfunction

  always_comb begin
    lookup_signal = '0;
    lookup_sugar  = '0;
    if (in_grid(lookup_X, lookup_Y)) begin
      lookup_signal = sig_q[cell_idx(lookup_X, lookup_Y)];
      lookup_sugar  = sug_q[cell_idx(lookup_X, lookup_Y)];
    end
  end

  always_comb begin
    render_signal = '0;
    render_sugar  = '0;
    if (in_grid(render_X, render_Y)) begin
      render_signal = sig_q[cell_idx(render_X, render_Y)];
      render_sugar  = sug_q[cell_idx(render_X, render_Y)];
    end
  end

  // A write landing on the swept cell wins outright; that cell skips this sweep's decay.
  always_comb begin
    sig_d     = sig_q;
    sug_d     = sug_q;
    take_ok_d = 1'b0;
    dep_sum   = '0;
    wr_hit    = wr.write_en && in_grid(wr.write_X, wr.write_Y);
    wr_idx    = cell_idx(wr.write_X, wr.write_Y);
    sw_idx    = cell_idx(ptr_x_q, ptr_y_q);
    collide   = wr_hit && (wr_idx == sw_idx);
    sw_sig    = sig_q[sw_idx];
    decay_amt = sw_sig >> DECAY_SHIFT;
    if (decay_amt == '0) decay_amt = SIGNAL_BITS'(1);

    if (state_q == SWEEP && !collide && sw_sig != '0) begin
      sig_d[sw_idx] = sw_sig - decay_amt;
    end

    if (wr_hit) begin
      case (wr.write_mode)
        2'b00: begin
          sig_d[wr_idx] = wr.write_signal;
          sug_d[wr_idx] = wr.write_sugar;
        end
        2'b01: begin
          dep_sum       = {1'b0, sig_q[wr_idx]} + {1'b0, wr.write_signal};
          sig_d[wr_idx] = dep_sum[SIGNAL_BITS] ? '1 : dep_sum[SIGNAL_BITS-1:0];
        end
        2'b10: begin
          if (sug_q[wr_idx] != '0) begin
            sug_d[wr_idx] = sug_q[wr_idx] - SUGAR_BITS'(1);
            take_ok_d     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_x_d = ptr_x_q;
    ptr_y_d = ptr_y_q;
    case (state_q)
      IDLE: begin
        if (evap_start) begin
          state_d = SWEEP;
          ptr_x_d = '0;
          ptr_y_d = '0;
        end
      end
      SWEEP: begin
        if (32'(ptr_x_q) == PIXELS_X - 1) begin
          ptr_x_d = '0;
          if (32'(ptr_y_q) == PIXELS_Y - 1) begin
            ptr_y_d = '0;
            state_d = DONE;
          end else begin
            ptr_y_d = ptr_y_q + Y_BITS'(1);
          end
        end else begin
          ptr_x_d = ptr_x_q + X_BITS'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      state_q   <= IDLE;
      ptr_x_q   <= '0;
      ptr_y_q   <= '0;
      take_ok_q <= 1'b0;
      sig_q     <= '{default: '0};
      sug_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      ptr_x_q   <= ptr_x_d;
      ptr_y_q   <= ptr_y_d;
      take_ok_q <= take_ok_d;
      sig_q     <= sig_d;
      sug_q     <= sug_d;
    end
  end

  assign wr.take_ok = take_ok_q;
  assign evap_busy  = (state_q == SWEEP);
  assign evap_done  = (state_q == DONE);
endmodule

// File: tb/tb_env_grid_evap.sv
// Randomised bench for env_grid_evap against a cell-array model of the grid,
// the write modes and a sweep that decays cell k on its k-th sweep cycle.
module tb_env_grid_evap;
  localparam int PX    = 64;
  localparam int PY    = 48;
  localparam int CELLS = PX * PY;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] lookup_X, lookup_Y, render_X, render_Y;
  logic [7:0] lookup_signal, render_signal;
  logic [3:0] lookup_sugar, render_sugar;
  logic       evap_start, evap_busy, evap_done;

  always #5 clk = ~clk;

  env_grid_evap_if #(.PIXELS_X(PX), .PIXELS_Y(PY), .SIGNAL_BITS(8), .SUGAR_BITS(4)) wr_if ();

  env_grid_evap #(.PIXELS_X(PX), .PIXELS_Y(PY), .SIGNAL_BITS(8), .SUGAR_BITS(4),
                  .DECAY_SHIFT(3)) dut (
    .newLocClock(clk), .RESET_SIM_n(rst_n), .wr(wr_if),
    .lookup_X(lookup_X), .lookup_Y(lookup_Y),
    .lookup_signal(lookup_signal), .lookup_sugar(lookup_sugar),
    .render_X(render_X), .render_Y(render_Y),
    .render_signal(render_signal), .render_sugar(render_sugar),
    .evap_start(evap_start), .evap_busy(evap_busy), .evap_done(evap_done)
  );

  int m_sig [CELLS];
  int m_sug [CELLS];
  int m_phase;   // 0 idle, 1 sweeping, 2 done pulse
  int m_k;       // index of the cell decayed on the current sweep cycle
  int exp_take;
  int total = 0;
  int bad   = 0;

  function automatic int decay(input int s);
    int d;
    d = s >> 3;
    if (d < 1) d = 1;
    return (s == 0) ? 0 : s - d;
  endfunction

  function automatic int exp_sig(input int x, input int y);
    if (x >= PX || y >= PY) return 0;
    return m_sig[y * PX + x];
  endfunction

  function automatic int exp_sug(input int x, input int y);
    if (x >= PX || y >= PY) return 0;
    return m_sug[y * PX + x];
  endfunction

  task automatic model_clear();
    foreach (m_sig[i]) begin
      m_sig[i] = 0;
      m_sug[i] = 0;
    end
    m_phase  = 0;
    m_k      = 0;
    exp_take = 0;
  endtask

  task automatic set_write(input bit en, input int x, input int y, input int mode,
                           input int s, input int g);
    wr_if.write_en     = en;
    wr_if.write_X      = 6'(x);
    wr_if.write_Y      = 6'(y);
    wr_if.write_mode   = 2'(mode);
    wr_if.write_signal = 8'(s);
    wr_if.write_sugar  = 4'(g);
  endtask

  // Advances the model by the inputs currently applied, then one clock edge.
  task automatic tick();
    int  idx;
    int  ws;
    bit  hit;
    exp_take = 0;
    hit = (wr_if.write_en === 1'b1) && (int'(wr_if.write_Y) < PY);
    idx = int'(wr_if.write_Y) * PX + int'(wr_if.write_X);
    ws  = int'(wr_if.write_signal);
    if (m_phase == 1 && !(hit && idx == m_k)) m_sig[m_k] = decay(m_sig[m_k]);
    if (hit) begin
      case (wr_if.write_mode)
        2'b00: begin
          m_sig[idx] = ws;
          m_sug[idx] = int'(wr_if.write_sugar);
        end
        2'b01: m_sig[idx] = (m_sig[idx] + ws > 255) ? 255 : m_sig[idx] + ws;
        2'b10: if (m_sug[idx] > 0) begin
          m_sug[idx] = m_sug[idx] - 1;
          exp_take = 1;
        end
        default: ;
      endcase
    end
    case (m_phase)
      0: if (evap_start === 1'b1) begin m_phase = 1; m_k = 0; end
      1: begin m_k = m_k + 1; if (m_k == CELLS) m_phase = 2; end
      default: m_phase = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic test_grid_scan(input string name);
    int errs = 0;
    for (int y = 0; y < 50; y++) begin
      for (int x = 0; x < PX; x++) begin
        lookup_X = 6'(x);          lookup_Y = 6'(y);
        render_X = 6'(PX - 1 - x); render_Y = 6'(49 - y);
        #1;
        if (lookup_signal !== 8'(exp_sig(x, y)) || lookup_sugar !== 4'(exp_sug(x, y)) ||
            render_signal !== 8'(exp_sig(PX - 1 - x, 49 - y)) ||
            render_sugar !== 4'(exp_sug(PX - 1 - x, 49 - y))) begin
          if (errs == 0)
            $display("FAIL %s at (%0d,%0d): got sig=%0d sug=%0d required sig=%0d sug=%0d",
                     name, x, y, lookup_signal, lookup_sugar, exp_sig(x, y), exp_sug(x, y));
          errs++;
        end
      end
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s: %0d mismatching reads, required 0", name, errs);
    end
  endtask

  task automatic test_reset();
    #1;
    lookup_X = 6'd3; lookup_Y = 6'd2; render_X = 6'd40; render_Y = 6'd30;
    #1;
    total++;
    if (evap_busy !== 1'b0 || evap_done !== 1'b0 || wr_if.take_ok !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: got busy=%b done=%b take_ok=%b required 0 0 0",
               evap_busy, evap_done, wr_if.take_ok);
    end
    total++;
    if (lookup_signal !== 8'd0 || lookup_sugar !== 4'd0 ||
        render_signal !== 8'd0 || render_sugar !== 4'd0) begin
      bad++;
      $display("FAIL reset_reads: got %0d/%0d %0d/%0d required zeros",
               lookup_signal, lookup_sugar, render_signal, render_sugar);
    end
    #4 rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_overwrite();
    int errs = 0;
    int x, y;
    set_write(1, 3, 2, 0, 200, 5);
    tick();
    set_write(0, 0, 0, 3, 0, 0);
    lookup_X = 6'd3; lookup_Y = 6'd2; render_X = 6'd3; render_Y = 6'd2;
    #1;
    total++;
    if (lookup_signal !== 8'd200 || lookup_sugar !== 4'd5 ||
        render_signal !== 8'd200 || render_sugar !== 4'd5) begin
      bad++;
      $display("FAIL overwrite_3_2: got %0d/%0d %0d/%0d required 200/5",
               lookup_signal, lookup_sugar, render_signal, render_sugar);
    end
    for (int i = 0; i < 20; i++) begin
      x = $urandom_range(0, PX - 1);
      y = $urandom_range(0, 49);
      if (x == 3 && y == 2) x = 4;
      lookup_X = 6'(x); lookup_Y = 6'(y); render_X = 6'(x); render_Y = 6'(y);
      #1;
      if (lookup_signal !== 8'd0 || lookup_sugar !== 4'd0 ||
          render_signal !== 8'd0 || render_sugar !== 4'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL overwrite_others: got %0d nonzero cells required 0", errs);
    end
  endtask

  task automatic test_deposit();
    int s, d, e;
    lookup_X = 6'd3; lookup_Y = 6'd2;
    set_write(1, 3, 2, 1, 100, 0);
    tick();
    total++;
    if (lookup_signal !== 8'd255 || lookup_sugar !== 4'd5) begin
      bad++;
      $display("FAIL deposit_sat: got %0d/%0d required 255/5", lookup_signal, lookup_sugar);
    end
    set_write(1, 3, 2, 1, 0, 0);
    tick();
    total++;
    if (lookup_signal !== 8'd255) begin
      bad++;
      $display("FAIL deposit_zero: got %0d required 255", lookup_signal);
    end
    lookup_X = 6'd10; lookup_Y = 6'd10;
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 255);
      d = $urandom_range(0, 255);
      e = (s + d > 255) ? 255 : s + d;
      set_write(1, 10, 10, 0, s, 7);
      tick();
      set_write(1, 10, 10, 1, d, 0);
      tick();
      total++;
      if (lookup_signal !== 8'(e) || lookup_sugar !== 4'd7 || e != exp_sig(10, 10)) begin
        bad++;
        $display("FAIL deposit_rand: %0d+%0d got %0d required %0d", s, d, lookup_signal, e);
      end
    end
    set_write(0, 0, 0, 3, 0, 0);
    tick();
  endtask

  task automatic test_take();
    int ok_seq [3] = '{1, 1, 0};
    int sg_seq [3] = '{1, 0, 0};
    set_write(1, 7, 7, 0, 9, 2);
    tick();
    lookup_X = 6'd7; lookup_Y = 6'd7;
    for (int i = 0; i < 3; i++) begin
      set_write(1, 7, 7, 2, 0, 0);
      tick();
      total++;
      if (wr_if.take_ok !== 1'(ok_seq[i]) || lookup_sugar !== 4'(sg_seq[i]) ||
          exp_take != ok_seq[i]) begin
        bad++;
        $display("FAIL take_seq%0d: got take_ok=%b sugar=%0d required %0d/%0d",
                 i, wr_if.take_ok, lookup_sugar, ok_seq[i], sg_seq[i]);
      end
    end
    set_write(1, 7, 2, 0, 0, 3);
    tick();
    set_write(1, 7, 50, 2, 0, 0);
    tick();
    lookup_X = 6'd7; lookup_Y = 6'd2; render_X = 6'd7; render_Y = 6'd50;
    #1;
    total++;
    if (wr_if.take_ok !== 1'b0 || lookup_sugar !== 4'd3 ||
        render_sugar !== 4'd0 || render_signal !== 8'd0) begin
      bad++;
      $display("FAIL take_out_of_range: got take_ok=%b sugar=%0d oob=%0d required 0/3/0",
               wr_if.take_ok, lookup_sugar, render_sugar);
    end
    set_write(1, 7, 2, 2, 0, 0);
    tick();
    set_write(0, 7, 2, 2, 0, 0);
    tick();
    total++;
    if (wr_if.take_ok !== 1'b0 || lookup_sugar !== 4'd2) begin
      bad++;
      $display("FAIL take_ok_clears: got take_ok=%b sugar=%0d required 0/2",
               wr_if.take_ok, lookup_sugar);
    end
  endtask

  task automatic test_evap();
    int cx [5] = '{0, 1, 10, 63, 30};
    int cy [5] = '{0, 0, 5, 47, 20};
    int cs [5] = '{0, 1, 7, 8, 200};
    int ce [5] = '{0, 0, 6, 7, 175};
    int n = 0;
    int done_in_sweep = 0;
    for (int i = 0; i < 5; i++) begin
      set_write(1, cx[i], cy[i], 0, cs[i], 1);
      tick();
    end
    set_write(0, 0, 0, 3, 0, 0);
    evap_start = 1'b1;
    tick();
    evap_start = 1'b0;
    while (evap_busy === 1'b1 && n < 5000) begin
      n++;
      if (n == 100) evap_start = 1'b1;
      tick();
      evap_start = 1'b0;
      if (evap_done === 1'b1 && evap_busy === 1'b1) done_in_sweep++;
    end
    total++;
    if (n != CELLS || done_in_sweep != 0) begin
      bad++;
      $display("FAIL evap_busy_len: got %0d cycles (done overlaps %0d) required %0d",
               n, done_in_sweep, CELLS);
    end
    total++;
    if (evap_done !== 1'b1 || evap_busy !== 1'b0) begin
      bad++;
      $display("FAIL evap_done_pulse: got done=%b busy=%b required 1/0", evap_done, evap_busy);
    end
    tick();
    tick();
    total++;
    if (evap_done !== 1'b0 || evap_busy !== 1'b0) begin
      bad++;
      $display("FAIL evap_not_queued: got done=%b busy=%b required 0/0", evap_done, evap_busy);
    end
    for (int i = 0; i < 5; i++) begin
      lookup_X = 6'(cx[i]); lookup_Y = 6'(cy[i]);
      #1;
      total++;
      if (lookup_signal !== 8'(ce[i]) || lookup_sugar !== 4'd1 || exp_sig(cx[i], cy[i]) != ce[i]) begin
        bad++;
        $display("FAIL evap_cell%0d: got %0d/%0d required %0d/1",
                 i, lookup_signal, lookup_sugar, ce[i]);
      end
    end
    test_grid_scan("evap_grid");
  endtask

  task automatic test_collision();
    int n = 0;
    set_write(1, 4, 0, 0, 40, 0); tick();
    set_write(1, 5, 0, 0, 80, 0); tick();
    set_write(1, 6, 0, 0, 50, 0); tick();
    set_write(0, 0, 0, 3, 0, 0);
    evap_start = 1'b1;
    tick();
    evap_start = 1'b0;
    repeat (5) tick();
    set_write(1, 5, 0, 1, 10, 0);
    tick();
    set_write(0, 0, 0, 3, 0, 0);
    while (evap_busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    tick();
    total++;
    if (evap_busy !== 1'b0) begin
      bad++;
      $display("FAIL collision_sweep_end: got busy=%b required 0", evap_busy);
    end
    lookup_X = 6'd5; lookup_Y = 6'd0; render_X = 6'd4; render_Y = 6'd0;
    #1;
    total++;
    if (lookup_signal !== 8'd90 || render_signal !== 8'd35) begin
      bad++;
      $display("FAIL collision_cell: got (5,0)=%0d (4,0)=%0d required 90/35",
               lookup_signal, render_signal);
    end
    render_X = 6'd6;
    #1;
    total++;
    if (render_signal !== 8'd44) begin
      bad++;
      $display("FAIL collision_right: got %0d required 44", render_signal);
    end
    test_grid_scan("collision_grid");
  endtask

  task automatic test_random();
    int x, y, mode;
    evap_start = 1'b0;
    for (int t = 0; t < 3300; t++) begin
      evap_start = (t == 20 || t == 1500) ? 1'b1 : 1'b0;
      if (m_phase == 1 && $urandom_range(0, 3) == 0) begin
        x = m_k % PX;
        y = m_k / PX;
      end else begin
        x = $urandom_range(0, PX - 1);
        y = $urandom_range(0, 49);
      end
      mode = $urandom_range(0, 3);
      set_write(1'($urandom_range(0, 1)), x, y, mode, $urandom_range(0, 255), $urandom_range(0, 15));
      tick();
      total++;
      if (wr_if.take_ok !== 1'(exp_take) || evap_busy !== (m_phase == 1) ||
          evap_done !== (m_phase == 2)) begin
        bad++;
        $display("FAIL random_ctrl t=%0d: got take_ok=%b busy=%b done=%b required %0d/%0d/%0d",
                 t, wr_if.take_ok, evap_busy, evap_done, exp_take, m_phase == 1, m_phase == 2);
      end
      lookup_X = 6'(x); lookup_Y = 6'(y);
      #1;
      total++;
      if (lookup_signal !== 8'(exp_sig(x, y)) || lookup_sugar !== 4'(exp_sug(x, y))) begin
        bad++;
        $display("FAIL random_read t=%0d (%0d,%0d): got %0d/%0d required %0d/%0d",
                 t, x, y, lookup_signal, lookup_sugar, exp_sig(x, y), exp_sug(x, y));
      end
    end
    set_write(0, 0, 0, 3, 0, 0);
    evap_start = 1'b0;
    tick();
    test_grid_scan("random_grid");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int flag_errs = 0;
    set_write(1, 30, 20, 0, 99, 9);
    tick();
    set_write(0, 0, 0, 3, 0, 0);
    evap_start = 1'b1;
    tick();
    evap_start = 1'b0;
    repeat (100) tick();
    set_write(1, 9, 9, 0, 77, 3);
    #2 rst_n = 1'b0;
    model_clear();
    lookup_X = 6'd30; lookup_Y = 6'd20;
    #1;
    total++;
    if (evap_busy !== 1'b0 || evap_done !== 1'b0 || wr_if.take_ok !== 1'b0 ||
        lookup_signal !== 8'd0 || lookup_sugar !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid_immediate: got busy=%b done=%b read=%0d/%0d required zeros",
               evap_busy, evap_done, lookup_signal, lookup_sugar);
    end
    @(posedge clk);
    #3;
    total++;
    if (evap_busy !== 1'b0 || evap_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_held: got busy=%b done=%b required 0/0", evap_busy, evap_done);
    end
    rst_n = 1'b1;
    set_write(0, 0, 0, 3, 0, 0);
    test_grid_scan("reset_mid_grid");
    repeat (5) begin
      tick();
      if (evap_busy !== 1'b0 || evap_done !== 1'b0) flag_errs++;
    end
    total++;
    if (flag_errs != 0) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %0d active cycles required 0", flag_errs);
    end
    set_write(1, 0, 0, 0, 16, 0); tick();
    set_write(1, 1, 0, 0, 16, 0); tick();
    set_write(0, 0, 0, 3, 0, 0);
    evap_start = 1'b1;
    tick();
    evap_start = 1'b0;
    tick();
    lookup_X = 6'd0; lookup_Y = 6'd0; render_X = 6'd1; render_Y = 6'd0;
    #1;
    total++;
    if (lookup_signal !== 8'd14 || render_signal !== 8'd16 || exp_sig(0, 0) != 14) begin
      bad++;
      $display("FAIL reset_mid_restart: got (0,0)=%0d (1,0)=%0d required 14/16",
               lookup_signal, render_signal);
    end
    while (evap_busy === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
    total++;
    if (n != CELLS - 1) begin
      bad++;
      $display("FAIL reset_mid_sweep_len: got %0d remaining cycles required %0d", n, CELLS - 1);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    evap_start = 1'b0;
    set_write(0, 0, 0, 3, 0, 0);
    lookup_X = '0; lookup_Y = '0; render_X = '0; render_Y = '0;
    model_clear();
    #2 rst_n = 1'b0;
    test_reset();
    test_overwrite();
    test_deposit();
    test_take();
    test_evap();
    test_collision();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
